// File: rtl/carbon_arch_pkg.sv
// Shared CAI architectural constants and the completion tuple type used by the
// am9513 completion path.
package carbon_arch_pkg;

    localparam int CARBON_CAI_COMP_REC_V1_SIZE_BYTES = 16;
    localparam int CARBON_CAI_COMP_OFF_TAG           = 0;
    localparam int CARBON_CAI_COMP_OFF_STATUS        = 4;
    localparam int CARBON_CAI_COMP_OFF_EXT_STATUS    = 6;
    localparam int CARBON_CAI_COMP_OFF_BYTES_WRITTEN = 8;
    localparam int CARBON_CAI_COMP_OFF_RESERVED      = 12;

    localparam logic [15:0] CARBON_CAI_STATUS_OK              = 16'h0000;
    localparam logic [15:0] CARBON_CAI_STATUS_INVALID_DESC    = 16'h0001;
    localparam logic [15:0] CARBON_CAI_STATUS_UNSUPPORTED_OP  = 16'h0002;
    localparam logic [15:0] CARBON_CAI_STATUS_MEM_FAULT       = 16'h0003;
    localparam logic [15:0] CARBON_CAI_STATUS_ARITH_EXCEPTION = 16'h0004;

    typedef struct packed {
        logic [31:0] tag;
        logic [15:0] status;
        logic [15:0] ext_status;
        logic [31:0] bytes_written;
    } comp_tuple_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DB   = 2'd3
    } comp_state_e;

    // Little-endian record word idx; status lands at byte 4, ext_status at byte 6.
    function automatic logic [31:0] comp_word(input comp_tuple_t t, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = t.tag;
            2'd1:    w = {t.ext_status, t.status};
            2'd2:    w = t.bytes_written;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cai_comp_fifo.sv
// Synchronous FIFO of completion tuples; a push is accepted while full if the
// head is popped in the same cycle.
module cai_comp_fifo
    import carbon_arch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  comp_tuple_t wdata,
    input  logic        pop,
    output comp_tuple_t rdata,
    output logic        empty,
    output logic        full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    comp_tuple_t      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {(PTR_W + 1){1'b0}});
    assign full      = (count_r == DEPTH_C);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cai_comp_writer.sv
// Serialises completion tuples into 16-byte CAI v1 records in the host ring and
// rings the doorbell once every word of a record has been acknowledged.
module cai_comp_writer
    import carbon_arch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_enable,
    input  logic [63:0]       cfg_comp_base,
    input  logic [31:0]       cfg_ring_mask,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_tag,
    input  logic [15:0]       in_status,
    input  logic [15:0]       in_ext_status,
    input  logic [31:0]       in_bytes_written,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic              mem_rsp_err,
    output logic              comp_doorbell,
    output logic [31:0]       comp_prod_idx,
    output logic              fault_sticky,
    output logic              busy
);
    localparam int REC_SHIFT = $clog2(CARBON_CAI_COMP_REC_V1_SIZE_BYTES);

    comp_state_e       state_r;
    comp_tuple_t       rec_r;
    comp_tuple_t       in_tuple_s;
    comp_tuple_t       fifo_head_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              push_s;
    logic              pop_s;
    logic              run_r;
    logic [63:0]       rec_base_r;
    logic [63:0]       slot_base_s;
    logic [63:0]       next_addr_s;
    logic [1:0]        word_r;
    logic [1:0]        word_nxt_s;
    logic              mem_req_valid_r;
    logic [ADDR_W-1:0] mem_req_addr_r;
    logic [31:0]       mem_req_wdata_r;
    logic [3:0]        mem_req_wstrb_r;
    logic              comp_doorbell_r;
    logic [31:0]       comp_prod_idx_r;
    logic              fault_sticky_r;

    assign in_tuple_s  = {in_tag, in_status, in_ext_status, in_bytes_written};
    // Draining does not depend on cfg_enable so queued records still commit.
    assign pop_s       = (state_r == ST_IDLE) && !fifo_empty_s;
    assign in_ready    = run_r && cfg_enable && (!fifo_full_s || pop_s);
    assign push_s      = in_valid && in_ready;
    assign slot_base_s = cfg_comp_base + ({32'd0, comp_prod_idx_r & cfg_ring_mask} << REC_SHIFT);
    assign word_nxt_s  = word_r + 2'd1;
    assign next_addr_s = rec_base_r + {60'd0, word_nxt_s, 2'b00};

    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign mem_req_wdata = mem_req_wdata_r;
    assign mem_req_wstrb = mem_req_wstrb_r;
    assign comp_doorbell = comp_doorbell_r;
    assign comp_prod_idx = comp_prod_idx_r;
    assign fault_sticky  = fault_sticky_r;
    assign busy          = !fifo_empty_s || (state_r != ST_IDLE);

    cai_comp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (in_tuple_s),
        .pop   (pop_s),
        .rdata (fifo_head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Record writer FSM with registered memory-port and doorbell outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            rec_r           <= '0;
            run_r           <= 1'b0;
            rec_base_r      <= 64'd0;
            word_r          <= 2'd0;
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= {ADDR_W{1'b0}};
            mem_req_wdata_r <= 32'd0;
            mem_req_wstrb_r <= 4'h0;
            comp_doorbell_r <= 1'b0;
            comp_prod_idx_r <= 32'd0;
            fault_sticky_r  <= 1'b0;
        end else begin
            run_r           <= 1'b1;
            mem_req_wstrb_r <= 4'hF;
            case (state_r)
                ST_IDLE: begin
                    comp_doorbell_r <= 1'b0;
                    if (pop_s) begin
                        rec_r           <= fifo_head_s;
                        rec_base_r      <= slot_base_s;
                        word_r          <= 2'd0;
                        mem_req_valid_r <= 1'b1;
                        mem_req_addr_r  <= slot_base_s[ADDR_W-1:0];
                        mem_req_wdata_r <= comp_word(fifo_head_s, 2'd0);
                        state_r         <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        state_r         <= ST_RSP;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_RSP: begin
                    if (!mem_rsp_valid) begin
                        state_r <= ST_RSP;
                    end else if (mem_rsp_err) begin
                        // Abandon the record: no doorbell, producer index untouched.
                        fault_sticky_r <= 1'b1;
                        state_r        <= ST_IDLE;
                    end else if (word_r != 2'd3) begin
                        word_r          <= word_nxt_s;
                        mem_req_valid_r <= 1'b1;
                        mem_req_addr_r  <= next_addr_s[ADDR_W-1:0];
                        mem_req_wdata_r <= comp_word(rec_r, word_nxt_s);
                        state_r         <= ST_REQ;
                    end else begin
                        comp_doorbell_r <= 1'b1;
                        state_r         <= ST_DB;
                    end
                end
                ST_DB: begin
                    comp_doorbell_r <= 1'b0;
                    comp_prod_idx_r <= comp_prod_idx_r + 32'd1;
                    state_r         <= ST_IDLE;
                end
                default: begin
                    mem_req_valid_r <= 1'b0;
                    comp_doorbell_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
